arbitro_suma: RTL and testbench

Sequencer and round-robin arbiter that shares one `suma` adder datapath between two requesters. Each requester hands over an operand pair with a valid/accept handshake. The block launches the adder with a one-cycle start pulse, waits for its done strobe under a timeout watchdog, and returns the result to the requester that owns the transaction. It sits between the operand sources and the `suma` instance, and only one addition is in flight at a time.

---
 rtl/suma_pkg.sv | 9 +
 rtl/rr_arbitro2.sv | 27 ++
 rtl/arbitro_suma.sv | 117 +++++++++++
 tb/tb_arbitro_suma.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/suma_pkg.sv
// Shared types and defaults for the arbitro_suma adder sequencer.
package suma_pkg;
  localparam int ANCHO_DEF   = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {LIBRE, EMITIR, ESPERAR, ENTREGAR} estado_t;
  typedef logic id_t;
endpackage

// File: rtl/rr_arbitro2.sv
// Two-requester round-robin grant logic with its priority pointer.
module rr_arbitro2
  import suma_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       habilitar,
  input  logic [1:0] valido,
  output logic [1:0] concesion,
  output id_t        ganador
);
  id_t prio;

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    ganador = prio;
    if (valido == 2'b01)      ganador = 1'b0;
    else if (valido == 2'b10) ganador = 1'b1;
    concesion = 2'b00;
    if (habilitar && (|valido)) concesion[ganador] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    prio <= 1'b0;
    else if (habilitar && (|valido)) prio <= ~ganador;
  end
endmodule

// File: rtl/arbitro_suma.sv
// Shares one external adder between two requesters: grant, start pulse,
// wait for done under a watchdog, then route the result to the owner.
module arbitro_suma
  import suma_pkg::*;
#(
  parameter int ANCHO   = ANCHO_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
)(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sol0_valido,
  input  logic [ANCHO-1:0] sol0_a,
  input  logic [ANCHO-1:0] sol0_b,
  output logic             sol0_aceptado,
  input  logic             sol1_valido,
  input  logic [ANCHO-1:0] sol1_a,
  input  logic [ANCHO-1:0] sol1_b,
  output logic             sol1_aceptado,
  output logic             res0_valido,
  output logic [ANCHO-1:0] res0_dato,
  output logic             res0_error,
  output logic             res1_valido,
  output logic [ANCHO-1:0] res1_dato,
  output logic             res1_error,
  output logic             suma_inicio,
  output logic [ANCHO-1:0] suma_a,
  output logic [ANCHO-1:0] suma_b,
  input  logic             suma_listo,
  input  logic [ANCHO-1:0] suma_resultado,
  output logic             ocupado
);
  localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT - 1);

  estado_t          estado, estado_sig;
  logic [1:0]       concesion;
  id_t              ganador, dueno;
  logic [ANCHO-1:0] op_a, op_b, resultado;
  logic             error;
  logic [CNT_W-1:0] cuenta;
  logic             libre, entregar;

  assign libre    = (estado == LIBRE);
  assign entregar = (estado == ENTREGAR);

  rr_arbitro2 u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .habilitar (libre),
    .valido    ({sol1_valido, sol0_valido}),
    .concesion (concesion),
    .ganador   (ganador)
  );

  // Accept is gated by reset so every output reads 0 while reset is held.
  assign sol0_aceptado = concesion[0] & reset_n;
  assign sol1_aceptado = concesion[1] & reset_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado <= LIBRE;
    else          estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      LIBRE:    if (|concesion) estado_sig = EMITIR;
      EMITIR:   estado_sig = ESPERAR;
      ESPERAR:  if (suma_listo || (cuenta == LIMITE)) estado_sig = ENTREGAR;
      ENTREGAR: estado_sig = LIBRE;
      default:  estado_sig = LIBRE;
    endcase
  end

  // Done strobe has priority over the watchdog when both land together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_a      <= '0;
      op_b      <= '0;
      dueno     <= 1'b0;
      resultado <= '0;
      error     <= 1'b0;
      cuenta    <= '0;
    end else begin
      case (estado)
        LIBRE: if (|concesion) begin
          dueno <= ganador;
          op_a  <= ganador ? sol1_a : sol0_a;
          op_b  <= ganador ? sol1_b : sol0_b;
        end
        EMITIR: cuenta <= '0;
        ESPERAR: begin
          cuenta <= cuenta + CNT_W'(1);
          if (suma_listo) begin
            resultado <= suma_resultado;
            error     <= 1'b0;
          end else if (cuenta == LIMITE) begin
            resultado <= '0;
            error     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign suma_inicio = (estado == EMITIR);
  assign suma_a      = op_a;
  assign suma_b      = op_b;
  assign ocupado     = !libre;

  assign res0_valido = entregar && (dueno == 1'b0);
  assign res1_valido = entregar && (dueno == 1'b1);
  assign res0_dato   = res0_valido ? resultado : '0;
  assign res1_dato   = res1_valido ? resultado : '0;
  assign res0_error  = res0_valido & error;
  assign res1_error  = res1_valido & error;
endmodule

// File: tb/tb_arbitro_suma.sv
// Bench for arbitro_suma: per-transaction model predicts grant, start pulse,
// result cycle and routing; the adder is played cycle by cycle by the bench.
module tb_arbitro_suma;
  localparam int ANCHO   = 32;
  localparam int TIMEOUT = 8;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             sol0_valido = 1'b0, sol1_valido = 1'b0;
  logic [ANCHO-1:0] sol0_a = '0, sol0_b = '0, sol1_a = '0, sol1_b = '0;
  logic             sol0_aceptado, sol1_aceptado;
  logic             res0_valido, res0_error, res1_valido, res1_error;
  logic [ANCHO-1:0] res0_dato, res1_dato;
  logic             suma_inicio, ocupado;
  logic [ANCHO-1:0] suma_a, suma_b;
  logic             suma_listo = 1'b0;
  logic [ANCHO-1:0] suma_resultado = '0;

  int errors = 0;
  int checks = 0;
  int prio_m = 0;

  arbitro_suma #(.ANCHO(ANCHO), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .sol0_valido(sol0_valido), .sol0_a(sol0_a), .sol0_b(sol0_b), .sol0_aceptado(sol0_aceptado),
    .sol1_valido(sol1_valido), .sol1_a(sol1_a), .sol1_b(sol1_b), .sol1_aceptado(sol1_aceptado),
    .res0_valido(res0_valido), .res0_dato(res0_dato), .res0_error(res0_error),
    .res1_valido(res1_valido), .res1_dato(res1_dato), .res1_error(res1_error),
    .suma_inicio(suma_inicio), .suma_a(suma_a), .suma_b(suma_b),
    .suma_listo(suma_listo), .suma_resultado(suma_resultado), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  // One transaction. k = cycles from start pulse to done strobe (0: never).
  task automatic txn(input logic v0, input logic v1,
                     input logic [ANCHO-1:0] a0, input logic [ANCHO-1:0] b0,
                     input logic [ANCHO-1:0] a1, input logic [ANCHO-1:0] b1,
                     input int k, input bit hold, input bit spur);
    logic [ANCHO-1:0] a, b, sum;
    logic err, r0, r1;
    int w, t_res;
    @(negedge clock);
    sol0_valido = v0; sol1_valido = v1;
    sol0_a = a0; sol0_b = b0; sol1_a = a1; sol1_b = b1;
    suma_listo = spur; suma_resultado = $urandom;
    w = (v0 && v1) ? prio_m : (v1 ? 1 : 0);
    a = (w == 1) ? a1 : a0;
    b = (w == 1) ? b1 : b0;
    #1;
    checks++;
    if (sol0_aceptado !== (w == 0) || sol1_aceptado !== (w == 1)) begin
      errors++;
      $display("FAIL aceptado: got %b%b expected winner %0d", sol1_aceptado, sol0_aceptado, w);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      errors++; $display("FAIL ocupado_libre: got %b expected 0", ocupado);
    end
    prio_m = 1 - w;
    err   = (k == 0);
    t_res = err ? 2 + TIMEOUT : 2 + k;
    sum   = err ? '0 : a + b;
    for (int t = 1; t <= t_res; t++) begin
      @(negedge clock);
      if (!hold) begin sol0_valido = 1'b0; sol1_valido = 1'b0; end
      sol0_a = $urandom; sol0_b = $urandom; sol1_a = $urandom; sol1_b = $urandom;
      suma_listo     = (k != 0 && t == 1 + k) || (spur && t == 1);
      suma_resultado = (k != 0 && t == 1 + k) ? a + b : $urandom;
      #1;
      r0 = (w == 0) && (t == t_res);
      r1 = (w == 1) && (t == t_res);
      checks++;
      if (sol0_aceptado !== 1'b0 || sol1_aceptado !== 1'b0) begin
        errors++; $display("FAIL aceptado_busy t=%0d: got %b%b expected 00", t, sol1_aceptado, sol0_aceptado);
      end
      checks++;
      if (suma_inicio !== (t == 1)) begin
        errors++; $display("FAIL inicio t=%0d: got %b expected %b", t, suma_inicio, t == 1);
      end
      checks++;
      if (ocupado !== 1'b1) begin
        errors++; $display("FAIL ocupado t=%0d: got %b expected 1", t, ocupado);
      end
      checks++;
      if (suma_a !== a || suma_b !== b) begin
        errors++; $display("FAIL operandos t=%0d: got %h/%h expected %h/%h", t, suma_a, suma_b, a, b);
      end
      checks++;
      if (res0_valido !== r0 || res0_dato !== (r0 ? sum : '0) || res0_error !== (r0 && err)) begin
        errors++;
        $display("FAIL res0 t=%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                 t, res0_valido, res0_dato, res0_error, r0, r0 ? sum : '0, r0 && err);
      end
      checks++;
      if (res1_valido !== r1 || res1_dato !== (r1 ? sum : '0) || res1_error !== (r1 && err)) begin
        errors++;
        $display("FAIL res1 t=%0d: got v=%b d=%h e=%b expected v=%b d=%h e=%b",
                 t, res1_valido, res1_dato, res1_error, r1, r1 ? sum : '0, r1 && err);
      end
    end
    suma_listo = 1'b0;
  endtask

  task automatic idle(input int n, input bit pulso);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      sol0_valido = 1'b0; sol1_valido = 1'b0;
      suma_listo = pulso; suma_resultado = $urandom;
      #1;
      checks++;
      if (ocupado !== 1'b0 || res0_valido !== 1'b0 || res1_valido !== 1'b0 || suma_inicio !== 1'b0) begin
        errors++;
        $display("FAIL idle: got ocupado=%b r0=%b r1=%b ini=%b expected all 0",
                 ocupado, res0_valido, res1_valido, suma_inicio);
      end
    end
    suma_listo = 1'b0;
  endtask

  task automatic check_zero(input string nombre);
    checks++;
    if ({sol0_aceptado, sol1_aceptado, res0_valido, res0_dato, res0_error, res1_valido, res1_dato,
         res1_error, suma_inicio, suma_a, suma_b, ocupado} !== '0) begin
      errors++;
      $display("FAIL %s: got acc=%b%b r0=%b/%h/%b r1=%b/%h/%b ini=%b a=%h b=%h ocup=%b expected all 0",
               nombre, sol1_aceptado, sol0_aceptado, res0_valido, res0_dato, res0_error,
               res1_valido, res1_dato, res1_error, suma_inicio, suma_a, suma_b, ocupado);
    end
  endtask

  task automatic test_reset;
    sol0_valido = 1'b1; sol1_valido = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_zero("reset_state");
    @(negedge clock);
    sol0_valido = 1'b0; sol1_valido = 1'b0;
    reset_n = 1'b1;
    prio_m = 0;
    idle(2, 1'b0);
  endtask

  task automatic test_rr;
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 1 + i, 1'b1, 1'b0);
  endtask

  task automatic test_single;
    txn(1'b1, 1'b0, 32'd2360, 32'd1000, $urandom, $urandom, 3, 1'b0, 1'b0);
  endtask

  task automatic test_timeout;
    txn(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 0, 1'b0, 1'b0);
    txn(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1'b0);
  endtask

  task automatic test_spurious;
    idle(3, 1'b1);
    txn(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, 4, 1'b0, 1'b1);
    idle(2, 1'b0);
  endtask

  task automatic test_timeout_edge;
    txn(1'b0, 1'b1, $urandom, $urandom, $urandom, $urandom, TIMEOUT, 1'b0, 1'b0);
    txn(1'b1, 1'b0, $urandom, $urandom, $urandom, $urandom, TIMEOUT - 1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    sol0_valido = 1'b1; sol0_a = $urandom; sol0_b = $urandom;
    #1;
    checks++;
    if (sol0_aceptado !== 1'b1) begin
      errors++; $display("FAIL reset_mid_accept: got %b expected 1", sol0_aceptado);
    end
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check_zero("reset_async");
    repeat (2) begin
      @(negedge clock);
      #1 check_zero("reset_held");
    end
    @(negedge clock);
    sol0_valido = 1'b0;
    reset_n = 1'b1;
    prio_m = 0;
    idle(1, 1'b0);
    txn(1'b1, 1'b1, $urandom, $urandom, $urandom, $urandom, 2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      logic v0, v1;
      int sel;
      sel = $urandom_range(1, 3);
      v0 = sel[0]; v1 = sel[1];
      txn(v0, v1, $urandom, $urandom, $urandom, $urandom,
          $urandom_range(0, TIMEOUT), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset;
    test_rr;
    test_single;
    test_timeout;
    test_spurious;
    test_timeout_edge;
    test_reset_mid;
    test_back_to_back;
    idle(2, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
